// File: rtl/iir_out_fifo.sv
// iir_out_fifo: output buffer downstream of the IIR filter.
// Holds filter samples in a small show-ahead FIFO and drains them to the
// consumer with a valid/ready handshake. Samples that arrive while the FIFO is
// full and nothing is popped are dropped and flagged on the sticky ovf bit.
// Optional build macro IIR_OUT_FIFO_OVF_CNT_EN adds an 8-bit saturating count
// of dropped samples on ovf_cnt; without it ovf_cnt is tied to 0.
module iir_out_fifo #(
  parameter int unsigned WIDTH = 11,
  parameter int unsigned DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [WIDTH-1:0]           din,
  input  logic                       vin,
  input  logic                       rdy,
  output logic [WIDTH-1:0]           dout,
  output logic                       vout,
  output logic                       full,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       ovf,
  output logic [7:0]                 ovf_cnt,
  input  logic                       clr_ovf
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = $clog2(DEPTH) + 1;
  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]    wp;
  logic [PW-1:0]    rp;
  logic [LW-1:0]    level_q;
  logic [LW-1:0]    level_nxt;
  logic             full_q;
  logic             ovf_q;
  logic             not_empty;
  logic             push;
  logic             pop;
  logic             drop;

  // Handshake decode: a pop frees a slot for a same-cycle push even when full.
  always_comb begin
    not_empty = (level_q != '0);
    pop       = not_empty && rdy;
    push      = vin && (!full_q || pop);
    drop      = vin && full_q && !pop;
  end

  // Next occupancy: net change of the push/pop pair.
  always_comb begin
    level_nxt = level_q;
    unique case ({push, pop})
      2'b10:   level_nxt = level_q + LW'(1);
      2'b01:   level_nxt = level_q - LW'(1);
      default: level_nxt = level_q;
    endcase
  end

  // Storage array; contents need no reset since reads are masked when empty.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wp] <= din;
    end
  end

  // Pointers, occupancy and full flag; DEPTH is a power of two so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wp      <= '0;
      rp      <= '0;
      level_q <= '0;
      full_q  <= 1'b0;
    end else begin
      if (push) begin
        wp <= wp + PW'(1);
      end
      if (pop) begin
        rp <= rp + PW'(1);
      end
      level_q <= level_nxt;
      full_q  <= (level_nxt == DEPTH_L);
    end
  end

  // Sticky overflow flag; a drop in the same cycle as a clear keeps the flag set.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_q <= 1'b0;
    end else if (drop) begin
      ovf_q <= 1'b1;
    end else if (clr_ovf) begin
      ovf_q <= 1'b0;
    end
  end

`ifdef IIR_OUT_FIFO_OVF_CNT_EN
  logic [7:0] cnt_q;

  // Saturating drop counter; a drop during a clear restarts the count at 1.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (drop) begin
      if (clr_ovf) begin
        cnt_q <= 8'd1;
      end else if (cnt_q != '1) begin
        cnt_q <= cnt_q + 8'd1;
      end
    end else if (clr_ovf) begin
      cnt_q <= '0;
    end
  end

  assign ovf_cnt = cnt_q;
`else
  assign ovf_cnt = '0;
`endif

  // Show-ahead head of FIFO, gated to zero when empty.
  always_comb begin
    vout  = not_empty;
    dout  = not_empty ? mem[rp] : '0;
    full  = full_q;
    level = level_q;
    ovf   = ovf_q;
  end

endmodule

// File: doc/iir_out_fifo.md
# iir_out_fifo

Output buffer placed directly downstream of the IIR filter. It captures every `dout`/`vout` sample the filter produces and holds it in a small FIFO. It then drains the samples to the consumer (data sink or next stage) with a valid/ready handshake, so consumer back-pressure never stalls or loses filter output silently. Overflow is detected and flagged.

## Interface
- `WIDTH`, 11, sample width; matches the filter output word.
- `DEPTH`, 8, FIFO depth in samples; power of two, at least 2.
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `din`  in  WIDTH  filter output sample.
- `vin`  in  1  filter output valid; one sample per cycle when high.
- `rdy`  in  1  consumer ready.
- `dout`  out  WIDTH  head-of-FIFO sample; 0 when empty.
- `vout`  out  1  head sample valid (= not empty).
- `full`  out  1  FIFO holds DEPTH samples.
- `level`  out  log2(DEPTH)+1  current occupancy, 0..DEPTH.
- `ovf`  out  1  sticky overflow flag.
- `ovf_cnt`  out  8  dropped-sample count, saturating.
- `clr_ovf`  in  1  synchronous clear of `ovf` and `ovf_cnt`.

## Operation
- Storage is a register array with write pointer `wp`, read pointer `rp`, and occupancy `level`. Both pointers wrap modulo DEPTH.
- Push condition: `vin` high and (not `full`, or pop in the same cycle). The push writes `din` at `wp` and increments `wp`.
- Pop condition: `vout` and `rdy` both high. The pop increments `rp`.
- `level` update: +1 on push only, −1 on pop only, unchanged on both or neither.
- Show-ahead read: `dout` is the array entry at `rp`, gated to 0 when empty. `vout` = (`level` ≠ 0).
- Full with simultaneous push and pop: both proceed, `level` stays at DEPTH, no drop.
- Empty with `vin`: the sample is written and `level` becomes 1. There is no same-cycle bypass, so `vout` rises the next cycle.
- Overflow: `vin` high, `full` high, and no pop in that cycle. The sample is discarded and the contents are unchanged. `ovf` is set and `ovf_cnt` is incremented, saturating at 255.
- `clr_ovf` clears `ovf` to 0 and `ovf_cnt` to 0. If an overflow occurs in the same cycle, the overflow wins: `ovf` = 1 and `ovf_cnt` = 1.
- Sample values pass through untouched; there is no arithmetic on data.

## Timing
- Reset values (asynchronous, immediate on `rst` high):
  - `wp` = `rp` = 0, `level` = 0.
  - `vout` = 0, `dout` = 0, `full` = 0.
  - `ovf` = 0, `ovf_cnt` = 0.
  - Array contents are don't-care; they are masked by the empty gating.
- Reset asserted mid-operation discards all buffered samples. The first `vin` after `rst` deasserts is treated as sample 0.
- Latency: a sample pushed at edge N is visible on `dout`/`vout` in the cycle after edge N, when the FIFO was empty.
- Throughput: one push and one pop per cycle sustained. With `rdy` held high, output order equals input order with 1-cycle latency.
- `full`, `level`, `ovf` and `ovf_cnt` are registered and update on the same edge as the push or pop that changes them.

## Configuration
- `IIR_OUT_FIFO_OVF_CNT_EN` defined: the 8-bit saturating `ovf_cnt` counter is built and behaves as described.
- Without the macro:
  - The counter is not built and `ovf_cnt` is tied to 0.
  - `ovf` and `clr_ovf` behave identically.
  - Drop behaviour is unchanged.

## Test plan
- Reset mid-stream: push 3 samples, assert `rst`. Required: `vout` = 0, `level` = 0, `dout` = 0 immediately. After release, push 0x155 → `dout` = 0x155 one cycle later.
- Pass-through: `rdy` = 1, `vin` = 1 for 20 cycles with ramp 0..19. Required: `dout` is the same ramp delayed 1 cycle, `level` ≤ 1, `ovf` = 0.
- Fill and drain (DEPTH = 8): `rdy` = 0, push 8 samples. Required: `full` = 1, `level` = 8. Then `rdy` = 1 → all 8 samples out in order, `vout` drops after the 8th.
- Overflow: full FIFO, `rdy` = 0, push 3 more (0x7FF, 0x400, 0x001). Required: contents unchanged, `ovf` = 1, `ovf_cnt` = 3. Pulse `clr_ovf` → both 0.
- Full with simultaneous push and pop: `level` = 8, `vin` = 1, `rdy` = 1 for 5 cycles. Required: `level` stays 8, no drop, `ovf` = 0, order preserved.
- Clear/overflow collision: `clr_ovf` in the same cycle as an overflow with `ovf_cnt` = 5. Required: `ovf` = 1, `ovf_cnt` = 1. Without `IIR_OUT_FIFO_OVF_CNT_EN`, `ovf_cnt` stays 0 throughout.
